// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_sub_pkg
// Description : Shared types and helpers for the bit-serial subtractor.
//               state_e    - controller states (IDLE, RUN, DONE)
//               cnt_width  - bit-counter width for a given operand width
// Revision    : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // The counter only has to reach WIDTH-1. A 1-bit counter is kept even
    // for WIDTH=1 so that no zero-width vector is ever declared.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : One-bit full subtractor cell, purely combinational.
//               Computes a - b - bin.
// Ports       : a    - minuend bit
//               b    - subtrahend bit
//               bin  - incoming borrow
//               d    - difference bit
//               bout - outgoing borrow
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when the bits match and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial subtractor, LSB first, one bit per clock.
//               Computes diff = a - b - borrow_in (mod 2^WIDTH) and the
//               final unsigned borrow. Valid/ready handshake on both sides.
//               Optional: define SERIAL_SUB_OVF_EN to add the 'ovf' output
//               (signed two's-complement overflow, valid with out_valid).
// Parameters  : WIDTH      - operand/result width, 1..64
// Ports       : clk        - rising-edge clock
//               rst_n      - asynchronous active-low reset
//               in_valid   - operands presented
//               in_ready   - block can accept operands (IDLE only)
//               a, b       - minuend, subtrahend
//               borrow_in  - incoming borrow
//               out_valid  - result available (DONE only)
//               out_ready  - consumer accepts result
//               diff       - a - b - borrow_in, modulo 2^WIDTH
//               borrow_out - 1 when a < b + borrow_in (unsigned)
//               ovf        - signed overflow (SERIAL_SUB_OVF_EN only)
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic             borrow_out
);

    localparam int              c_CW   = cnt_width(WIDTH);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

    state_e            r_state;
    state_e            w_state_next;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_run;
    logic              w_last;

    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_diff;
    logic [WIDTH-1:0]  w_diff_next;
    logic              r_br;
    logic [c_CW-1:0]   r_cnt;
    logic              w_d;
    logic              w_bout;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign w_accept  = in_valid && w_in_ready;
    assign w_run     = (r_state == RUN);
    assign w_last    = (r_cnt == c_LAST);
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;

    // ------------------------------------------------------------------
    // Bit cell: always works on bit 0 of the operand shift registers
    // ------------------------------------------------------------------
    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_br),
        .d    (w_d),
        .bout (w_bout)
    );

    // Difference bits enter at the MSB and move down, so after WIDTH
    // shifts the first (LSB) result bit has reached position 0.
    generate
        if (WIDTH == 1) begin : g_diff_w1
            assign w_diff_next = w_d;
        end else begin : g_diff_wn
            assign w_diff_next = {w_d, r_diff[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_br   <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a   <= a;
            r_b   <= b;
            r_br  <= borrow_in;
            r_cnt <= '0;
        end else if (w_run) begin
            r_a    <= r_a >> 1;
            r_b    <= r_b >> 1;
            r_diff <= w_diff_next;
            r_br   <= w_bout;
            // Hold on the last bit so the counter never wraps.
            if (!w_last) begin
                r_cnt <= r_cnt + c_CW'(1);
            end
        end
    end

    // The borrow flip-flop holds the final borrow once RUN completes.
    assign diff       = r_diff;
    assign borrow_out = r_br;

`ifdef SERIAL_SUB_OVF_EN
    logic r_ovf;

    // On the last bit, bit 0 of the shift registers is the operands' MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_ovf <= 1'b0;
        end else if (w_run && w_last) begin
            r_ovf <= (r_a[0] ^ r_b[0]) & (w_d ^ r_a[0]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor. A driver issues
//               operations and pushes expected results into a queue; a
//               monitor pops and compares whenever out_valid presents a new
//               result, checks latency, stability under backpressure and
//               in_ready while busy. Honours SERIAL_SUB_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    parameter int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             b;
        logic             o;
        int unsigned      acc;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             borrow_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             borrow_out;
    logic             ovf;

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;
    int unsigned cyc    = 0;
    int          hold_req = 0;
    bit          have   = 0;
    exp_t        q[$];

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .diff       (diff),
`ifdef SERIAL_SUB_OVF_EN
        .ovf        (ovf),
`endif
        .borrow_out (borrow_out)
    );

`ifndef SERIAL_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain wide arithmetic for the unsigned result and borrow,
    // true signed arithmetic range check for overflow.
    function automatic exp_t model(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                                   input logic bini);
        exp_t        e;
        logic [WIDTH:0] full;
        longint      sa, sb, res, smax, smin;
        full = {1'b0, ai} - {1'b0, bi} - {{WIDTH{1'b0}}, bini};
        e.d  = full[WIDTH-1:0];
        e.b  = full[WIDTH];
        sa   = longint'($signed(ai));
        sb   = longint'($signed(bi));
        res  = sa - sb - longint'(bini);
        smax = (longint'(1) <<< (WIDTH - 1)) - 1;
        smin = -(longint'(1) <<< (WIDTH - 1));
        e.o  = (res > smax) || (res < smin);
        e.acc = 0;
        return e;
    endfunction

    // Issue one operation; scr=1 scrambles inputs during RUN.
    task automatic do_op(input logic [WIDTH-1:0] ai, input logic [WIDTH-1:0] bi,
                         input logic bini, input bit scr);
        exp_t e;
        int   n;
        @(negedge clk);
        a = ai; b = bi; borrow_in = bini; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL accept_timeout: actual=in_ready 0 required=in_ready 1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(ai, bi, bini);
        e.acc = cyc;
        q.push_back(e);
        if (scr) begin
            for (int i = 0; i < WIDTH - 2; i++) begin
                @(negedge clk);
                a = WIDTH'($urandom); b = WIDTH'($urandom);
                borrow_in = 1'($urandom); in_valid = 1'($urandom);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || have) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 64'(q.size()), 64'd0);
    endtask

    // Monitor / consumer
    initial begin : monitor
        exp_t             e;
        logic [WIDTH-1:0] cap_d;
        logic             cap_b, cap_o;
        int               hold_cnt;
        bit               prev_hs;
        hold_cnt = 0; prev_hs = 0; out_ready = 1'b0;
        cap_d = '0; cap_b = 1'b0; cap_o = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                have = 0; prev_hs = 0; out_ready = 1'b0;
                continue;
            end
            if (prev_hs) chk("out_valid_drop", 64'(out_valid), 64'd0);
            prev_hs = 0;
            if (out_valid) begin
                chk("in_ready_busy", 64'(in_ready), 64'd0);
                if (!have) begin
                    if (q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL unexpected_result: actual=diff %0h required=no result", diff);
                    end else begin
                        e = q.pop_front();
                        chk("diff", 64'(diff), 64'(e.d));
                        chk("borrow_out", 64'(borrow_out), 64'(e.b));
                        chk("latency", 64'(cyc - e.acc), 64'(WIDTH));
`ifdef SERIAL_SUB_OVF_EN
                        chk("ovf", 64'(ovf), 64'(e.o));
`endif
                    end
                    have = 1;
                    cap_d = diff; cap_b = borrow_out; cap_o = ovf;
                    hold_cnt = hold_req; hold_req = 0;
                end else begin
                    chk("diff_stable", 64'(diff), 64'(cap_d));
                    chk("borrow_stable", 64'(borrow_out), 64'(cap_b));
                    chk("ovf_stable", 64'(ovf), 64'(cap_o));
                end
                if (hold_cnt > 0) begin
                    out_ready = 1'b0;
                    hold_cnt--;
                end else begin
                    out_ready = ($urandom % 4) != 0;
                end
                if (out_ready) begin
                    have = 0;
                    prev_hs = 1;
                end
            end else begin
                out_ready = 1'($urandom);
            end
        end
    end

    // Stimulus
    initial begin : driver
        logic [WIDTH-1:0] ra, rb;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
        #2;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_diff", 64'(diff), 64'd0);
        chk("rst_borrow_out", 64'(borrow_out), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_op(WIDTH'(5), WIDTH'(3), 1'b0, 1'b0);
        do_op(WIDTH'(3), WIDTH'(5), 1'b0, 1'b1);
        do_op(WIDTH'(0), WIDTH'(0), 1'b1, 1'b1);
        do_op(WIDTH'(0), WIDTH'(1), 1'b0, 1'b0);
        do_op(WIDTH'(8'h80), WIDTH'(1), 1'b0, 1'b1);
        drain();

        // Backpressure: hold out_ready low for five DONE cycles.
        hold_req = 5;
        do_op(WIDTH'(8'hA7), WIDTH'(8'h3C), 1'b1, 1'b1);
        drain();

        // Reset during RUN cycle 4.
        if (WIDTH >= 5) begin
            do_op(WIDTH'(8'h5A), WIDTH'(8'h11), 1'b0, 1'b0);
            repeat (3) @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("midrst_in_ready", 64'(in_ready), 64'd1);
            chk("midrst_out_valid", 64'(out_valid), 64'd0);
            chk("midrst_diff", 64'(diff), 64'd0);
            chk("midrst_borrow_out", 64'(borrow_out), 64'd0);
            chk("midrst_ovf", 64'(ovf), 64'd0);
            void'(q.pop_back());
            @(negedge clk);
            rst_n = 1'b1;
        end
        do_op({WIDTH{1'b1}}, WIDTH'(1), 1'b0, 1'b1);
        drain();

        // Random back-to-back traffic with random backpressure.
        for (int i = 0; i < 40; i++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if (i % 10 == 3) ra = '0;
            if (i % 10 == 7) rb = {WIDTH{1'b1}};
            do_op(ra, rb, 1'($urandom), 1'($urandom));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
